// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : mem_ctrl_if
// Brief  : Request/response bundle between the fetcher, the load/store buffer,
//          the byte-wide RAM/IO port and mem_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  // Instruction fetch side
  logic                  if_to_mc_ready;
  logic [ADDR_WIDTH-1:0] if_to_mc_PC;
  logic                  mc_to_if_ready;
  logic [31:0]           mc_to_if_inst;

  // Load/store buffer side
  logic                  lsb_to_mc_valid;
  logic                  lsb_to_mc_wr;
  logic [ADDR_WIDTH-1:0] lsb_to_mc_addr;
  logic [1:0]            lsb_to_mc_len;
  logic                  lsb_to_mc_signed;
  logic [31:0]           lsb_to_mc_data;
  logic                  mc_to_lsb_ready;
  logic [31:0]           mc_to_lsb_data;

  // Byte-wide RAM/IO port
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  // Controller view
  modport slave (
    input  if_to_mc_ready, if_to_mc_PC,
    input  lsb_to_mc_valid, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len,
    input  lsb_to_mc_signed, lsb_to_mc_data,
    input  mem_din,
    output mc_to_if_ready, mc_to_if_inst,
    output mc_to_lsb_ready, mc_to_lsb_data,
    output mem_dout, mem_a, mem_wr
  );

  // Requester / memory view
  modport master (
    output if_to_mc_ready, if_to_mc_PC,
    output lsb_to_mc_valid, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len,
    output lsb_to_mc_signed, lsb_to_mc_data,
    output mem_din,
    input  mc_to_if_ready, mc_to_if_inst,
    input  mc_to_lsb_ready, mc_to_lsb_data,
    input  mem_dout, mem_a, mem_wr
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_ctrl
// Brief  : Byte-serial arbiter between instruction fetch and load/store onto a
//          single byte-wide RAM/IO port; assembles little-endian words.
//          Optional macro MC_IO_STALL_EN: stall IO-space store bytes while the
//          UART buffer reports full.
// Rev    : 1.0  initial release
// ============================================================================
module mem_ctrl #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  wire logic clk_in,
  input  wire logic rst_in,
  input  wire logic rdy_in,
  input  wire logic rollback,
  input  wire logic io_buffer_full,
  mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [2:0]            r_nbytes;
  logic [1:0]            r_len;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr;
  logic                  r_if_ready;
  logic [31:0]           r_if_inst;
  logic                  r_lsb_ready;
  logic [31:0]           r_lsb_data;

  logic [1:0]            w_cap_idx;
  logic [31:0]           w_word;
  logic [31:0]           w_load_ext;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_next_a;
  logic [7:0]            w_next_byte;
  logic [2:0]            w_req_nbytes;
  logic                  w_stall;

  // Byte k-1 arrives while byte k is being addressed; merge it into the word.
  always_comb begin
    w_cap_idx = r_cnt[1:0] - 2'd1;
    w_word    = r_buf;
    w_word[{w_cap_idx, 3'b000} +: 8] = bus.mem_din;
    w_last      = (r_cnt == r_nbytes);
    w_next_a    = r_base + ADDR_WIDTH'(r_cnt);
    w_next_byte = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
    case (r_len)
      2'b00:   w_load_ext = r_signed ? {{24{w_word[7]}}, w_word[7:0]}
                                     : {24'd0, w_word[7:0]};
      2'b01:   w_load_ext = r_signed ? {{16{w_word[15]}}, w_word[15:0]}
                                     : {16'd0, w_word[15:0]};
      default: w_load_ext = w_word;
    endcase
    case (bus.lsb_to_mc_len)
      2'b00:   w_req_nbytes = 3'd1;
      2'b01:   w_req_nbytes = 3'd2;
      default: w_req_nbytes = 3'd4;
    endcase
  end

`ifdef MC_IO_STALL_EN
  assign w_stall = (r_state == S_STORE) && (r_mem_a[17:16] == IO_BASE_HI)
                   && io_buffer_full;
`else
  logic [2:0] w_unused_io;
  assign w_unused_io = {io_buffer_full, IO_BASE_HI};
  assign w_stall     = 1'b0;
`endif

  // Write strobe and pulses are masked while frozen or stalled so nothing commits.
  assign bus.mem_a           = r_mem_a;
  assign bus.mem_dout        = r_mem_dout;
  assign bus.mem_wr          = r_mem_wr & rdy_in & ~w_stall;
  assign bus.mc_to_if_ready  = r_if_ready & rdy_in;
  assign bus.mc_to_if_inst   = r_if_inst;
  assign bus.mc_to_lsb_ready = r_lsb_ready & rdy_in;
  assign bus.mc_to_lsb_data  = r_lsb_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_nbytes    <= 3'd0;
      r_len       <= 2'd0;
      r_signed    <= 1'b0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_mem_a     <= '0;
      r_mem_dout  <= 8'd0;
      r_mem_wr    <= 1'b0;
      r_if_ready  <= 1'b0;
      r_if_inst   <= 32'd0;
      r_lsb_ready <= 1'b0;
      r_lsb_data  <= 32'd0;
    end else if (rdy_in) begin
      r_if_ready  <= 1'b0;
      r_lsb_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.lsb_to_mc_valid) begin
            r_base   <= bus.lsb_to_mc_addr;
            r_mem_a  <= bus.lsb_to_mc_addr;
            r_cnt    <= 3'd1;
            r_nbytes <= w_req_nbytes;
            r_len    <= bus.lsb_to_mc_len;
            r_signed <= bus.lsb_to_mc_signed;
            r_buf    <= 32'd0;
            if (bus.lsb_to_mc_wr) begin
              r_wdata    <= bus.lsb_to_mc_data;
              r_mem_dout <= bus.lsb_to_mc_data[7:0];
              r_mem_wr   <= 1'b1;
              r_state    <= S_STORE;
            end else begin
              r_state    <= S_LOAD;
            end
          end else if (bus.if_to_mc_ready && !rollback) begin
            r_base   <= bus.if_to_mc_PC;
            r_mem_a  <= bus.if_to_mc_PC;
            r_cnt    <= 3'd1;
            r_nbytes <= 3'd4;
            r_len    <= 2'b10;
            r_signed <= 1'b0;
            r_buf    <= 32'd0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH, S_LOAD: begin
          if (rollback) begin
            r_cnt   <= 3'd0;
            r_state <= S_DONE;
          end else begin
            r_buf <= w_word;
            if (w_last) begin
              r_cnt   <= 3'd0;
              r_state <= S_DONE;
              if (r_state == S_FETCH) begin
                r_if_ready <= 1'b1;
                r_if_inst  <= w_word;
              end else begin
                r_lsb_ready <= 1'b1;
                r_lsb_data  <= w_load_ext;
              end
            end else begin
              r_mem_a <= w_next_a;
              r_cnt   <= r_cnt + 3'd1;
            end
          end
        end
        S_STORE: begin
          // Stores ignore rollback: the data is already architecturally committed.
          if (!w_stall) begin
            if (w_last) begin
              r_mem_wr    <= 1'b0;
              r_mem_a     <= '0;
              r_lsb_ready <= 1'b1;
              r_cnt       <= 3'd0;
              r_state     <= S_DONE;
            end else begin
              r_mem_a    <= w_next_a;
              r_mem_dout <= w_next_byte;
              r_cnt      <= r_cnt + 3'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_ctrl
// Brief  : Directed self-checking bench for mem_ctrl with a byte RAM model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic rollback;
  logic io_buffer_full;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rollback       (rollback),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM model: read data for the address presented is available by the next edge.
  logic [7:0] ram [0:1023];
  logic       pre_we;
  logic [9:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk_in) begin
    if (pre_we)
      ram[pre_addr] <= pre_data;
    else if (bus.mem_wr)
      ram[bus.mem_a[9:0]] <= bus.mem_dout;
  end
  assign bus.mem_din = ram[bus.mem_a[9:0]];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic req_fetch(input logic [31:0] pc);
    bus.if_to_mc_ready = 1'b1;
    bus.if_to_mc_PC    = pc;
  endtask

  task automatic req_lsb(input logic wr, input logic [31:0] a, input logic [1:0] len,
                         input logic sgn, input logic [31:0] d);
    bus.lsb_to_mc_valid  = 1'b1;
    bus.lsb_to_mc_wr     = wr;
    bus.lsb_to_mc_addr   = a;
    bus.lsb_to_mc_len    = len;
    bus.lsb_to_mc_signed = sgn;
    bus.lsb_to_mc_data   = d;
  endtask

  // Full 4-edge fetch from an idle controller, checking the returned word.
  task automatic fetch_word(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    req_fetch(pc);
    step();
    chk({tag, "_a0"}, bus.mem_a, pc);
    step(); step(); step();
    chk({tag, "_nopulse"}, {31'd0, bus.mc_to_if_ready}, 32'd0);
    step();
    chk({tag, "_pulse"}, {31'd0, bus.mc_to_if_ready}, 32'd1);
    chk({tag, "_inst"}, bus.mc_to_if_inst, exp);
    bus.if_to_mc_ready = 1'b0;
    step();
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.if_to_mc_ready = 1'b0; bus.if_to_mc_PC = '0;
    bus.lsb_to_mc_valid = 1'b0; bus.lsb_to_mc_wr = 1'b0; bus.lsb_to_mc_addr = '0;
    bus.lsb_to_mc_len = 2'b00; bus.lsb_to_mc_signed = 1'b0; bus.lsb_to_mc_data = '0;

    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'hA0); poke(10'h103, 8'h00);
    poke(10'h200, 8'h80); poke(10'h210, 8'h34); poke(10'h211, 8'hF2);
    step();

    chk("rst_mem_a",    bus.mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("rst_mem_wr",   {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_if_rdy",   {31'd0, bus.mc_to_if_ready}, 32'd0);
    chk("rst_lsb_rdy",  {31'd0, bus.mc_to_lsb_ready}, 32'd0);
    chk("rst_inst",     bus.mc_to_if_inst, 32'd0);
    chk("rst_lsb_data", bus.mc_to_lsb_data, 32'd0);
    rst_in = 1'b0;

    // Basic fetch with per-cycle address walk
    req_fetch(32'h100);
    step(); chk("f_a0", bus.mem_a, 32'h100);
    step(); chk("f_a1", bus.mem_a, 32'h101);
    step(); chk("f_a2", bus.mem_a, 32'h102);
    step(); chk("f_a3", bus.mem_a, 32'h103);
    chk("f_nopulse", {31'd0, bus.mc_to_if_ready}, 32'd0);
    step(); chk("f_pulse", {31'd0, bus.mc_to_if_ready}, 32'd1);
    chk("f_inst", bus.mc_to_if_inst, 32'h00A00513);
    bus.if_to_mc_ready = 1'b0;
    step(); chk("f_done_rdy", {31'd0, bus.mc_to_if_ready}, 32'd0);
    chk("f_inst_hold", bus.mc_to_if_inst, 32'h00A00513);

    // Byte loads, signed then unsigned
    req_lsb(1'b0, 32'h200, 2'b00, 1'b1, 32'd0);
    step(); chk("lbs_a0", bus.mem_a, 32'h200);
    chk("lbs_nopulse", {31'd0, bus.mc_to_lsb_ready}, 32'd0);
    step(); chk("lbs_pulse", {31'd0, bus.mc_to_lsb_ready}, 32'd1);
    chk("lbs_data", bus.mc_to_lsb_data, 32'hFFFFFF80);
    bus.lsb_to_mc_valid = 1'b0;
    step();
    req_lsb(1'b0, 32'h200, 2'b00, 1'b0, 32'd0);
    step(); step(); chk("lbu_pulse", {31'd0, bus.mc_to_lsb_ready}, 32'd1);
    chk("lbu_data", bus.mc_to_lsb_data, 32'h00000080);
    bus.lsb_to_mc_valid = 1'b0;
    step(); chk("lbu_data_hold", bus.mc_to_lsb_data, 32'h00000080);

    // Word store, then read it back
    req_lsb(1'b1, 32'h300, 2'b10, 1'b0, 32'hDEADBEEF);
    step(); chk("sw_wr0", {31'd0, bus.mem_wr}, 32'd1);
    chk("sw_a0", bus.mem_a, 32'h300); chk("sw_d0", {24'd0, bus.mem_dout}, 32'hEF);
    step(); chk("sw_a1", bus.mem_a, 32'h301); chk("sw_d1", {24'd0, bus.mem_dout}, 32'hBE);
    step(); chk("sw_a2", bus.mem_a, 32'h302); chk("sw_d2", {24'd0, bus.mem_dout}, 32'hAD);
    step(); chk("sw_a3", bus.mem_a, 32'h303); chk("sw_d3", {24'd0, bus.mem_dout}, 32'hDE);
    chk("sw_wr3", {31'd0, bus.mem_wr}, 32'd1);
    step(); chk("sw_pulse", {31'd0, bus.mc_to_lsb_ready}, 32'd1);
    chk("sw_wr_end", {31'd0, bus.mem_wr}, 32'd0);
    chk("sw_a_end", bus.mem_a, 32'd0);
    bus.lsb_to_mc_valid = 1'b0;
    step();
    fetch_word("sw_rb", 32'h300, 32'hDEADBEEF);

    // Contention: signed half load wins, fetch follows after the bubble
    req_fetch(32'h100);
    req_lsb(1'b0, 32'h210, 2'b01, 1'b1, 32'd0);
    step(); chk("ct_a0", bus.mem_a, 32'h210);
    step(); chk("ct_a1", bus.mem_a, 32'h211);
    chk("ct_nopulse", {31'd0, bus.mc_to_lsb_ready}, 32'd0);
    step(); chk("ct_lsb_pulse", {31'd0, bus.mc_to_lsb_ready}, 32'd1);
    chk("ct_lsb_data", bus.mc_to_lsb_data, 32'hFFFFF234);
    chk("ct_if_quiet", {31'd0, bus.mc_to_if_ready}, 32'd0);
    bus.lsb_to_mc_valid = 1'b0;
    step(); chk("ct_bubble", {31'd0, bus.mc_to_lsb_ready | bus.mc_to_if_ready}, 32'd0);
    fetch_word("ct_fetch", 32'h100, 32'h00A00513);

    // Rollback two cycles into a fetch aborts it
    req_fetch(32'h100);
    step(); step(); step();
    rollback = 1'b1;
    step(); chk("rb_f_nopulse", {31'd0, bus.mc_to_if_ready}, 32'd0);
    rollback = 1'b0; bus.if_to_mc_ready = 1'b0;
    step(); chk("rb_f_nopulse2", {31'd0, bus.mc_to_if_ready}, 32'd0);
    req_lsb(1'b0, 32'h200, 2'b00, 1'b1, 32'd0);
    step(); chk("rb_idle_accept", bus.mem_a, 32'h200);
    step(); chk("rb_idle_data", bus.mc_to_lsb_data, 32'hFFFFFF80);
    bus.lsb_to_mc_valid = 1'b0;
    step();

    // Rollback held in IDLE blocks fetch acceptance
    rollback = 1'b1;
    req_fetch(32'h100);
    for (int i = 0; i < 6; i++) begin
      step(); chk("rb_idle_block", {31'd0, bus.mc_to_if_ready}, 32'd0);
    end
    bus.if_to_mc_ready = 1'b0;

    // Store proceeds to completion under rollback
    rollback = 1'b0;
    req_lsb(1'b1, 32'h300, 2'b10, 1'b0, 32'h11223344);
    step(); rollback = 1'b1;
    step(); chk("rb_st_wr1", {31'd0, bus.mem_wr}, 32'd1);
    chk("rb_st_d1", {24'd0, bus.mem_dout}, 32'h33);
    step(); chk("rb_st_wr2", {31'd0, bus.mem_wr}, 32'd1);
    step(); chk("rb_st_wr3", {31'd0, bus.mem_wr}, 32'd1);
    chk("rb_st_d3", {24'd0, bus.mem_dout}, 32'h11);
    step(); chk("rb_st_pulse", {31'd0, bus.mc_to_lsb_ready}, 32'd1);
    rollback = 1'b0; bus.lsb_to_mc_valid = 1'b0;
    step();
    fetch_word("rb_st_rb", 32'h300, 32'h11223344);

    // Freeze mid-fetch with rdy_in low
    req_fetch(32'h100);
    step(); step();
    rdy_in = 1'b0;
    step(); chk("frz_a_hold", bus.mem_a, 32'h101);
    step(); chk("frz_a_hold2", bus.mem_a, 32'h101);
    rdy_in = 1'b1;
    step(); step(); chk("frz_nopulse", {31'd0, bus.mc_to_if_ready}, 32'd0);
    step(); chk("frz_pulse", {31'd0, bus.mc_to_if_ready}, 32'd1);
    chk("frz_inst", bus.mc_to_if_inst, 32'h00A00513);
    bus.if_to_mc_ready = 1'b0;
    step();

    // Reset mid-fetch aborts silently
    req_fetch(32'h100);
    step(); step();
    rst_in = 1'b1;
    step(); chk("rstm_a", bus.mem_a, 32'd0);
    chk("rstm_inst", bus.mc_to_if_inst, 32'd0);
    rst_in = 1'b0; bus.if_to_mc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("rstm_nopulse", {31'd0, bus.mc_to_if_ready}, 32'd0);
    end

    // IO-space byte store against a full UART buffer
    io_buffer_full = 1'b1;
    req_lsb(1'b1, 32'h00030000, 2'b00, 1'b0, 32'h0000005A);
`ifdef MC_IO_STALL_EN
    step(); chk("io_stall0", {31'd0, bus.mem_wr}, 32'd0);
    step(); chk("io_stall1", {31'd0, bus.mem_wr}, 32'd0);
    chk("io_nopulse", {31'd0, bus.mc_to_lsb_ready}, 32'd0);
    step(); chk("io_stall2", {31'd0, bus.mem_wr}, 32'd0);
    io_buffer_full = 1'b0;
    #1; chk("io_resume_wr", {31'd0, bus.mem_wr}, 32'd1);
    step(); chk("io_pulse", {31'd0, bus.mc_to_lsb_ready}, 32'd1);
`else
    step(); chk("io_nostall_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("io_nostall_d", {24'd0, bus.mem_dout}, 32'h5A);
    step(); chk("io_nostall_pulse", {31'd0, bus.mc_to_lsb_ready}, 32'd1);
`endif
    io_buffer_full = 1'b0; bus.lsb_to_mc_valid = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
